// File: rtl/sgd_x_updated_rd_stream.sv
// Read-side drain for the x_updated BRAM: sweeps every word once per start pulse and
// streams it out over valid/ready through a credit-managed first-word-fall-through FIFO.
`ifndef NUM_BITS_PER_BANK
`define NUM_BITS_PER_BANK 4
`endif
`ifndef BIT_WIDTH_OF_BANK
`define BIT_WIDTH_OF_BANK 3
`endif
`ifndef ENGINE_NUM_WIDTH
`define ENGINE_NUM_WIDTH 1
`endif
`ifndef DIS_X_BIT_DEPTH
`define DIS_X_BIT_DEPTH 9
`endif

module sgd_x_updated_rd_stream #(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [31:0]                       dimension,
    output logic                              x_rd_en,
    output logic [`DIS_X_BIT_DEPTH-1:0]       x_rd_addr,
    input  logic [`NUM_BITS_PER_BANK*32-1:0]  x_rd_data,
    output logic [`NUM_BITS_PER_BANK*32-1:0]  m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic                              busy,
    output logic                              done
);

    localparam int LG = `BIT_WIDTH_OF_BANK + `ENGINE_NUM_WIDTH;
    localparam int DW = `NUM_BITS_PER_BANK * 32;
    localparam int AW = `DIS_X_BIT_DEPTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, LEN, READ, DRAIN, DONE} state_t;

    state_t              state;
    logic [31:0]         dim_reg;
    logic [31:0]         main_counter;
    logic [31:0]         mc_calc;
    logic [AW-1:0]       rd_addr;
    logic [CW-1:0]       credits;
    logic [CW-1:0]       fifo_count;
    logic [RD_LATENCY-1:0] vpipe;
    logic [RD_LATENCY-1:0] lpipe;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [DW-1:0]       mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic                issue;
    logic                issue_last;
    logic                hs;
    logic                fifo_wr;

    // Word count rounds the dimension up to whole groups of G elements.
    assign mc_calc    = (dim_reg >> LG) + {31'd0, |dim_reg[LG-1:0]};
    assign issue      = (state == READ) && (credits < CW'(FIFO_DEPTH));
    assign issue_last = ({{(32-AW){1'b0}}, rd_addr} == main_counter - 32'd1);
    assign x_rd_en    = issue;
    assign x_rd_addr  = rd_addr;
    assign fifo_wr    = vpipe[RD_LATENCY-1];
    assign m_valid    = (fifo_count != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign m_last     = m_valid & last_mem[rd_ptr];
    assign hs         = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            dim_reg      <= '0;
            main_counter <= '0;
            rd_addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dim_reg <= dimension;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        state   <= LEN;
                    end
                end
                LEN: begin
                    main_counter <= mc_calc;
                    if (mc_calc != 32'd0) begin
                        state <= READ;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + 1'b1;
                        if (issue_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && m_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credits cover both in-flight reads and buffered words, so the FIFO can never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe      <= '0;
            lpipe      <= '0;
            credits    <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            vpipe[0] <= issue;
            lpipe[0] <= issue & issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
            credits    <= credits + CW'(issue) - CW'(hs);
            fifo_count <= fifo_count + CW'(fifo_wr) - CW'(hs);
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (hs)      rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr]      <= x_rd_data;
            last_mem[wr_ptr] <= lpipe[RD_LATENCY-1];
        end
    end

endmodule
